br_resolve_unit: RTL

- Parametrised, registered successor to the execute-stage branch comparator.
- Evaluates the branch condition, computes the architectural target, and checks both against the front-end prediction.
- Presents one registered resolution record per branch to fetch over a valid/ready handshake, and keeps saturating branch/mispredict statistics.
- Sits between EX operand forwarding and the fetch redirect logic.

---
 rtl/br_resolve_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/br_resolve_unit.sv
// br_resolve_unit
// Registered branch resolution stage that sits between EX operand forwarding
// and the fetch redirect logic. It evaluates the branch condition and computes
// the architectural target. It compares both against the front-end prediction.
// One resolution record per branch goes to fetch over a valid/ready handshake.
// The unit also keeps saturating branch and mispredict counters.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   in_valid / in_ready    record handshake from EX
//   in_pc, in_rs, in_rt    branch PC and forwarded operands
//   in_imm, in_jidx        branch offset and J-type index fields
//   in_cond                one-hot condition: 0 EQ,1 NE,2 GEZ,3 GTZ,4 LEZ,5 LTZ,6 J,7 JR
//   in_link                instruction writes the link register
//   in_pred_taken/target   front-end prediction
//   flush                  drop the held record and block capture this cycle
//   out_valid / out_ready  resolution record handshake to fetch
//   out_taken, out_redirect_pc, out_mispredict, out_adel, out_link_we, out_link_data
//   cnt_branches, cnt_mispred   saturating statistics
module br_resolve_unit #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 32,
  parameter int NUM_COND = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [DATA_W-1:0]   in_rs,
  input  logic [DATA_W-1:0]   in_rt,
  input  logic [15:0]         in_imm,
  input  logic [25:0]         in_jidx,
  input  logic [NUM_COND-1:0] in_cond,
  input  logic                in_link,
  input  logic                in_pred_taken,
  input  logic [PC_W-1:0]     in_pred_target,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_taken,
  output logic [PC_W-1:0]     out_redirect_pc,
  output logic                out_mispredict,
  output logic                out_adel,
  output logic                out_link_we,
  output logic [DATA_W-1:0]   out_link_data,
  output logic [CNT_W-1:0]    cnt_branches,
  output logic [CNT_W-1:0]    cnt_mispred
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Low 28 bits of the PC are replaced by {jidx, 2'b00} on a J.
  localparam logic [PC_W-1:0]  J_MASK  = PC_W'(28'hFFF_FFFF);

  logic [7:0]      cond8_s;
  logic [2:0]      sel_s;
  logic            any_s;
  logic            cond_true_s;
  logic            taken_s;
  logic            adel_s;
  logic            mis_s;
  logic            capture_s;
  logic            rs_msb_s;
  logic            rs_zero_s;
  logic [PC_W-1:0] pc4_s;
  logic [PC_W-1:0] pc8_s;
  logic [PC_W-1:0] br_tgt_s;
  logic [PC_W-1:0] j_tgt_s;
  logic [PC_W-1:0] jr_tgt_s;
  logic [PC_W-1:0] tgt_s;
  logic [PC_W-1:0] redirect_s;

  // Saturating increment shared by both statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Only the eight defined condition bits take part; higher bits are reserved.
  assign cond8_s   = in_cond[7:0];
  assign rs_msb_s  = in_rs[DATA_W-1];
  assign rs_zero_s = (in_rs == '0);

  assign pc4_s    = in_pc + PC_W'(4);
  assign pc8_s    = in_pc + PC_W'(8);
  assign br_tgt_s = pc4_s + {{(PC_W-18){in_imm[15]}}, in_imm, 2'b00};
  assign j_tgt_s  = (pc4_s & ~J_MASK) | PC_W'({in_jidx, 2'b00});
  assign jr_tgt_s = PC_W'(in_rs);

  assign in_ready  = ~out_valid | out_ready;
  assign capture_s = in_valid & in_ready & ~flush;

  // Priority pick: scanning from the top down leaves the lowest set index.
  always_comb begin
    sel_s = 3'd0;
    any_s = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sel_s = cond8_s[i] ? 3'(i) : sel_s;
      any_s = any_s | cond8_s[i];
    end
  end

  // Condition evaluation and target selection for the winning condition.
  always_comb begin
    cond_true_s = 1'b0;
    tgt_s       = br_tgt_s;
    case (sel_s)
      3'd0: cond_true_s = (in_rs == in_rt);
      3'd1: cond_true_s = (in_rs != in_rt);
      3'd2: cond_true_s = ~rs_msb_s;
      3'd3: cond_true_s = ~rs_msb_s & ~rs_zero_s;
      3'd4: cond_true_s = rs_msb_s | rs_zero_s;
      3'd5: cond_true_s = rs_msb_s;
      3'd6: begin
        cond_true_s = 1'b1;
        tgt_s       = j_tgt_s;
      end
      3'd7: begin
        cond_true_s = 1'b1;
        tgt_s       = jr_tgt_s;
      end
      default: begin
        cond_true_s = 1'b0;
        tgt_s       = br_tgt_s;
      end
    endcase
  end

  // An empty condition resolves as not-taken; a misaligned JR hands redirect
  // to the exception path, so it never reports a mispredict.
  assign taken_s    = any_s & cond_true_s;
  assign adel_s     = any_s & (sel_s == 3'd7) & (in_rs[1:0] != 2'b00);
  assign mis_s      = ~adel_s & ((taken_s != in_pred_taken) |
                                 (taken_s & (tgt_s != in_pred_target)));
  assign redirect_s = taken_s ? tgt_s : pc8_s;

  // Output record register and statistics; counters move on capture only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid       <= 1'b0;
      out_taken       <= 1'b0;
      out_redirect_pc <= '0;
      out_mispredict  <= 1'b0;
      out_adel        <= 1'b0;
      out_link_we     <= 1'b0;
      out_link_data   <= '0;
      cnt_branches    <= '0;
      cnt_mispred     <= '0;
    end else begin
      if (capture_s) begin
        out_valid       <= 1'b1;
        out_taken       <= taken_s;
        out_redirect_pc <= redirect_s;
        out_mispredict  <= mis_s;
        out_adel        <= adel_s;
        out_link_we     <= in_link;
        out_link_data   <= DATA_W'(pc8_s);
        // Records with no condition are not branches and feed no statistics.
        if (any_s) begin
          cnt_branches <= sat_inc(cnt_branches);
          if (mis_s) begin
            cnt_mispred <= sat_inc(cnt_mispred);
          end
        end
      end else if (flush || out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
